cypher_sum_display: RTL

- Downstream stage of the cypher detector. It consumes the detector's 10-bit `sum` output and shows it on four seven-segment displays.
- Conversion uses a sequential shift-add-3 (double-dabble) binary-to-BCD converter that re-converts whenever `sum` changes.
- Outputs are the registered BCD digits, decoded segment patterns with leading-zero blanking, and status flags for the board top level.

---
 rtl/cypher_sum_display.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cypher_sum_display.sv
// cypher_sum_display
// Converts the cypher detector's binary sum to four BCD digits using a
// sequential shift-add-3 (double-dabble) engine, then drives four
// seven-segment displays from the registered digits with optional
// leading-zero blanking. Re-converts whenever `sum` changes.

module cypher_sum_display #(
    parameter int SUM_W          = 10,
    parameter bit BLANK_LEADING  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [SUM_W-1:0] sum,
    output logic [15:0]      bcd,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    // Scratch holds {bcd field, binary field}; the binary field shifts into the BCD field.
    localparam int SCR_W = 16 + SUM_W;
    localparam int CNT_W = $clog2(SUM_W + 1);

    // Active-low pattern with every segment dark.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [SUM_W-1:0]   sum_q;
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   scratch_adj;
    logic [SCR_W-1:0]   scratch_shift;
    logic [CNT_W-1:0]   cnt;
    logic               start;
    logic               last_iter;

    // A new conversion begins on a changed input, or unconditionally until the first result exists.
    assign start     = (state == ST_IDLE) && ((sum != sum_q) || !valid);
    assign last_iter = (cnt == CNT_W'(SUM_W - 1));

    // Active-low seven-segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles go dark.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one load cycle, SUM_W shift cycles, one publish cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start) state_next = ST_CONVERT;
            ST_CONVERT: if (last_iter) state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // One double-dabble iteration: add 3 to each BCD nibble >= 5, then shift left.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[SUM_W + 4*i +: 4] >= 4'd5) begin
                scratch_adj[SUM_W + 4*i +: 4] = scratch[SUM_W + 4*i +: 4] + 4'd3;
            end
        end
        scratch_shift = scratch_adj << 1;
    end

    // Datapath and status registers; bcd only changes in the publish cycle, so no partial value escapes.
    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_q   <= '0;
            scratch <= '0;
            cnt     <= '0;
            bcd     <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sum_q   <= sum;
                        scratch <= {16'b0, sum};
                        cnt     <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_CONVERT: begin
                    scratch <= scratch_shift;
                    cnt     <= cnt + CNT_W'(1);
                end
                ST_DONE: begin
                    bcd   <= scratch[SCR_W-1 -: 16];
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Segment decode from the registered digits, with leading-zero blanking and polarity select.
    always_comb begin
        logic [3:0] d3, d2, d1, d0;
        logic       blank3, blank2, blank1, blank0;
        logic [6:0] raw3, raw2, raw1, raw0;

        d3 = bcd[15:12];
        d2 = bcd[11:8];
        d1 = bcd[7:4];
        d0 = bcd[3:0];

        blank3 = !valid || (BLANK_LEADING && (d3 == 4'd0));
        blank2 = !valid || (BLANK_LEADING && (d3 == 4'd0) && (d2 == 4'd0));
        blank1 = !valid || (BLANK_LEADING && (d3 == 4'd0) && (d2 == 4'd0) && (d1 == 4'd0));
        blank0 = !valid;

        raw3 = blank3 ? SEG_BLANK : seg7(d3);
        raw2 = blank2 ? SEG_BLANK : seg7(d2);
        raw1 = blank1 ? SEG_BLANK : seg7(d1);
        raw0 = blank0 ? SEG_BLANK : seg7(d0);

        hex3 = SEG_ACTIVE_LOW ? raw3 : ~raw3;
        hex2 = SEG_ACTIVE_LOW ? raw2 : ~raw2;
        hex1 = SEG_ACTIVE_LOW ? raw1 : ~raw1;
        hex0 = SEG_ACTIVE_LOW ? raw0 : ~raw0;
    end

endmodule
